drw_mkaddr: RTL and testbench

Read-address generator for the drawing engine. It turns a rectangle command (source/destination base, stride, origin, size) into a stream of AXI-legal burst descriptors, one per burst, for the VRAM read controller. It keeps independent source and destination cursors, and each cursor advances when the read controller commits a burst. It sits between the command decoder (upstream, `START` + geometry) and the VRAM read controller (downstream, `ADDR_VALID`/`*_COMMIT` handshake).

---
 rtl/drw_mkaddr.sv | 220 ++++++++++++++++++++++
 tb/tb_drw_mkaddr.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/drw_mkaddr.sv
// Read-address generator for the drawing engine: turns a rectangle command into
// a stream of 4 KB-safe burst descriptors for independent source/destination cursors.
module drw_mkaddr #(
    parameter int MAXBURST = 16
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        START,
    input  logic        BLT_CMD,
    input  logic        BLEND_ALPHA,
    input  logic [28:0] SRC_BASE,
    input  logic [28:0] DST_BASE,
    input  logic [11:0] SRC_STRIDE,
    input  logic [11:0] DST_STRIDE,
    input  logic [10:0] SRC_X,
    input  logic [10:0] SRC_Y,
    input  logic [10:0] DST_X,
    input  logic [10:0] DST_Y,
    input  logic [10:0] WIDTH,
    input  logic [10:0] HEIGHT,
    output logic        ADDR_VALID,
    output logic [28:0] SRC_ADDR,
    output logic [28:0] DST_ADDR,
    output logic [7:0]  SRC_LEN,
    output logic [7:0]  DST_LEN,
    output logic        SRC_FIN,
    output logic        DST_FIN,
    input  logic        SRC_COMMIT,
    input  logic        DST_COMMIT,
    output logic        BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN} state_t;

    typedef struct packed {
        logic [28:0] row;
        logic [28:0] col;
        logic [10:0] rem;
        logic [10:0] rows;
        logic        done;
    } cursor_t;

    typedef struct packed {
        logic [28:0] addr;
        logic [7:0]  len;
        logic        fin;
    } desc_t;

    state_t      state_q, state_n;
    logic        addr_valid_q;
    logic        blt_q, blend_q;
    logic [10:0] width_q, height_q;
    logic [28:0] src_base_q, dst_base_q;
    logic [11:0] src_stride_q, dst_stride_q;
    logic [10:0] src_x_q, src_y_q, dst_x_q, dst_y_q;
    logic [22:0] src_mul_q, dst_mul_q;
    cursor_t     src_q, dst_q, src_next, dst_next, src_start, dst_start;
    desc_t       src_desc_q, dst_desc_q;
    logic        accept, src_ok, dst_ok;

    // Burst length limited by MAXBURST, the rest of the line and the 4 KB page.
    function automatic logic [10:0] beats_of(input cursor_t c);
        logic [10:0] room, b;
        room = 11'd1024 - {1'b0, c.col[11:2]};
        b    = (c.rem < 11'(MAXBURST)) ? c.rem : 11'(MAXBURST);
        if (room < b) b = room;
        return b;
    endfunction

    function automatic desc_t desc_of(input cursor_t c);
        desc_t       d;
        logic [10:0] b;
        b      = beats_of(c);
        d.addr = c.col;
        d.len  = 8'(b - 11'd1);
        d.fin  = (c.rows == 11'd1) && (c.rem == b);
        return d;
    endfunction

    function automatic cursor_t advance(input cursor_t c, input logic [11:0] stride,
                                        input logic [10:0] width);
        cursor_t     n;
        logic [10:0] b;
        b = beats_of(c);
        n = c;
        if (c.rem > b) begin
            n.col = c.col + 29'({b, 2'b00});
            n.rem = c.rem - b;
        end else if (c.rows > 11'd1) begin
            n.row  = c.row + 29'({stride, 2'b00});
            n.col  = c.row + 29'({stride, 2'b00});
            n.rem  = width;
            n.rows = c.rows - 11'd1;
        end else begin
            n.done = 1'b1;
        end
        return n;
    endfunction

    function automatic cursor_t start_of(input logic [28:0] base, input logic [22:0] mul,
                                         input logic [10:0] x, input logic [10:0] width,
                                         input logic [10:0] height);
        cursor_t     c;
        logic [23:0] lin;
        lin    = {1'b0, mul} + {13'd0, x};
        c.row  = base + 29'({lin, 2'b00});
        c.col  = c.row;
        c.rem  = width;
        c.rows = height;
        c.done = 1'b0;
        return c;
    endfunction

    assign accept = START && (BLT_CMD || BLEND_ALPHA) && (WIDTH != 11'd0) && (HEIGHT != 11'd0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        src_ok    = (state_q == S_RUN) && addr_valid_q && SRC_COMMIT && !src_q.done;
        dst_ok    = (state_q == S_RUN) && addr_valid_q && DST_COMMIT && !dst_q.done;
        src_next  = src_ok ? advance(src_q, src_stride_q, width_q) : src_q;
        dst_next  = dst_ok ? advance(dst_q, dst_stride_q, width_q) : dst_q;
        src_start = start_of(src_base_q, src_mul_q, src_x_q, width_q, height_q);
        dst_start = start_of(dst_base_q, dst_mul_q, dst_x_q, width_q, height_q);
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_n = S_SETUP;
            S_SETUP: state_n = S_RUN;
            S_RUN:   if (addr_valid_q && src_next.done && dst_next.done) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ACLK) begin
        if (ARST) state_q <= S_IDLE;
        else      state_q <= state_n;
    end

    // NOTE: datapath registers are reset too, so descriptors read 0 straight out of reset.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            addr_valid_q <= 1'b0;
            blt_q        <= 1'b0;
            blend_q      <= 1'b0;
            width_q      <= '0;
            height_q     <= '0;
            src_base_q   <= '0;
            dst_base_q   <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            src_x_q      <= '0;
            src_y_q      <= '0;
            dst_x_q      <= '0;
            dst_y_q      <= '0;
            src_mul_q    <= '0;
            dst_mul_q    <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            src_desc_q   <= '0;
            dst_desc_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    blt_q        <= BLT_CMD;
                    blend_q      <= BLEND_ALPHA;
                    width_q      <= WIDTH;
                    height_q     <= HEIGHT;
                    src_base_q   <= SRC_BASE;
                    dst_base_q   <= DST_BASE;
                    src_stride_q <= SRC_STRIDE;
                    dst_stride_q <= DST_STRIDE;
                    src_x_q      <= SRC_X;
                    src_y_q      <= SRC_Y;
                    dst_x_q      <= DST_X;
                    dst_y_q      <= DST_Y;
                end
                S_SETUP: begin
                    src_mul_q  <= 23'(src_y_q) * 23'(src_stride_q);
                    dst_mul_q  <= 23'(dst_y_q) * 23'(dst_stride_q);
                    src_q      <= '{row: '0, col: '0, rem: '0, rows: '0, done: !blt_q};
                    dst_q      <= '{row: '0, col: '0, rem: '0, rows: '0, done: !blend_q};
                    src_desc_q <= '0;
                    dst_desc_q <= '0;
                end
                S_RUN: if (!addr_valid_q) begin
                    // First RUN cycle: products are ready, load cursors and first descriptors.
                    if (blt_q) begin
                        src_q      <= src_start;
                        src_desc_q <= desc_of(src_start);
                    end
                    if (blend_q) begin
                        dst_q      <= dst_start;
                        dst_desc_q <= desc_of(dst_start);
                    end
                    addr_valid_q <= 1'b1;
                end else begin
                    src_q <= src_next;
                    dst_q <= dst_next;
                    if (src_ok && !src_next.done) src_desc_q <= desc_of(src_next);
                    if (dst_ok && !dst_next.done) dst_desc_q <= desc_of(dst_next);
                    if (src_next.done && dst_next.done) addr_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ADDR_VALID = addr_valid_q;
    assign BUSY       = (state_q != S_IDLE);
    assign SRC_ADDR   = src_desc_q.addr;
    assign SRC_LEN    = src_desc_q.len;
    assign SRC_FIN    = src_desc_q.fin;
    assign DST_ADDR   = dst_desc_q.addr;
    assign DST_LEN    = dst_desc_q.len;
    assign DST_FIN    = dst_desc_q.fin;

endmodule

// File: tb/tb_drw_mkaddr.sv
// Bench for drw_mkaddr: a per-cursor burst list is built from the rectangle geometry
// and compared against the DUT descriptors under randomized commit patterns.
module tb_drw_mkaddr;
    localparam int MAXBURST = 16;

    logic        ACLK = 1'b0;
    logic        ARST, START, BLT_CMD, BLEND_ALPHA, SRC_COMMIT, DST_COMMIT;
    logic [28:0] SRC_BASE, DST_BASE;
    logic [11:0] SRC_STRIDE, DST_STRIDE;
    logic [10:0] SRC_X, SRC_Y, DST_X, DST_Y, WIDTH, HEIGHT;
    logic        ADDR_VALID, SRC_FIN, DST_FIN, BUSY;
    logic [28:0] SRC_ADDR, DST_ADDR;
    logic [7:0]  SRC_LEN, DST_LEN;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [28:0] addr;
        logic [7:0]  len;
        logic        fin;
    } burst_t;

    burst_t exp_src[$];
    burst_t exp_dst[$];

    drw_mkaddr #(.MAXBURST(MAXBURST)) dut (
        .ACLK(ACLK), .ARST(ARST), .START(START), .BLT_CMD(BLT_CMD), .BLEND_ALPHA(BLEND_ALPHA),
        .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .SRC_STRIDE(SRC_STRIDE), .DST_STRIDE(DST_STRIDE),
        .SRC_X(SRC_X), .SRC_Y(SRC_Y), .DST_X(DST_X), .DST_Y(DST_Y),
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_VALID(ADDR_VALID),
        .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .SRC_LEN(SRC_LEN), .DST_LEN(DST_LEN),
        .SRC_FIN(SRC_FIN), .DST_FIN(DST_FIN), .SRC_COMMIT(SRC_COMMIT), .DST_COMMIT(DST_COMMIT),
        .BUSY(BUSY)
    );

    always #5 ACLK = ~ACLK;

    // Reference: walk every row of the rectangle and chop it into page-safe bursts.
    task automatic build(input logic [28:0] base, input logic [11:0] stride,
                         input logic [10:0] x, input logic [10:0] y,
                         input logic [10:0] w, input logic [10:0] h, input bit is_dst);
        longint      lin;
        logic [28:0] a;
        int          rem, room, beats;
        burst_t      b;
        for (int r = 0; r < int'(h); r++) begin
            lin = (longint'(y) + r) * longint'(stride) + longint'(x);
            a   = base + 29'(lin * 4);
            rem = int'(w);
            while (rem > 0) begin
                room  = 1024 - int'(a[11:2]);
                beats = MAXBURST;
                if (rem < beats) beats = rem;
                if (room < beats) beats = room;
                b.addr = a;
                b.len  = 8'(beats - 1);
                b.fin  = (r == int'(h) - 1) && (rem == beats);
                if (is_dst) exp_dst.push_back(b);
                else        exp_src.push_back(b);
                a   = a + 29'(beats * 4);
                rem = rem - beats;
            end
        end
    endtask

    task automatic set_cmd(input bit blt, input bit blend, input logic [28:0] sb, input logic [28:0] db,
                           input logic [11:0] ss, input logic [11:0] ds,
                           input logic [10:0] sx, input logic [10:0] sy,
                           input logic [10:0] dx, input logic [10:0] dy,
                           input logic [10:0] w, input logic [10:0] h);
        BLT_CMD = blt;  BLEND_ALPHA = blend;
        SRC_BASE = sb;  DST_BASE = db;
        SRC_STRIDE = ss; DST_STRIDE = ds;
        SRC_X = sx; SRC_Y = sy; DST_X = dx; DST_Y = dy;
        WIDTH = w;  HEIGHT = h;
    endtask

    // mode 0: random commits, 1: both every cycle, 2: alternate src/dst
    task automatic run_blit(input string name, input bit blt, input bit blend,
                            input logic [28:0] sb, input logic [28:0] db,
                            input logic [11:0] ss, input logic [11:0] ds,
                            input logic [10:0] sx, input logic [10:0] sy,
                            input logic [10:0] dx, input logic [10:0] dy,
                            input logic [10:0] w, input logic [10:0] h, input int mode);
        burst_t zero, last_s, last_d, ws, wd;
        int     cyc;
        bit     fin_loop, sc, dc;
        zero = '{29'd0, 8'd0, 1'b0};
        last_s = zero;
        last_d = zero;
        exp_src.delete();
        exp_dst.delete();
        if (blt)   build(sb, ss, sx, sy, w, h, 1'b0);
        if (blend) build(db, ds, dx, dy, w, h, 1'b1);

        @(negedge ACLK);
        set_cmd(blt, blend, sb, db, ss, ds, sx, sy, dx, dy, w, h);
        START = 1'b1; SRC_COMMIT = 1'b0; DST_COMMIT = 1'b0;
        @(negedge ACLK);
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || ADDR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: BUSY=%b ADDR_VALID=%b, want 1/0", name, BUSY, ADDR_VALID);
        end
        @(negedge ACLK);
        checks++;
        if (BUSY !== 1'b1 || ADDR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL %s setup: BUSY=%b ADDR_VALID=%b, want 1/0", name, BUSY, ADDR_VALID);
        end
        set_cmd(1'($urandom), 1'($urandom), 29'($urandom), 29'($urandom), 12'($urandom), 12'($urandom),
                11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom));

        cyc = 0;
        fin_loop = 1'b0;
        while (!fin_loop) begin
            @(negedge ACLK);
            if (exp_src.size() == 0 && exp_dst.size() == 0) begin
                checks++;
                if (ADDR_VALID !== 1'b0 || BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL %s end: ADDR_VALID=%b BUSY=%b, want 0/0", name, ADDR_VALID, BUSY);
                end
                fin_loop = 1'b1;
            end else begin
                ws = !blt ? zero : (exp_src.size() != 0 ? exp_src[0] : last_s);
                wd = !blend ? zero : (exp_dst.size() != 0 ? exp_dst[0] : last_d);
                checks++;
                if (ADDR_VALID !== 1'b1 || BUSY !== 1'b1) begin
                    errors++;
                    $display("FAIL %s valid c%0d: ADDR_VALID=%b BUSY=%b, want 1/1", name, cyc, ADDR_VALID, BUSY);
                end
                checks++;
                if (SRC_ADDR !== ws.addr || SRC_LEN !== ws.len || SRC_FIN !== ws.fin) begin
                    errors++;
                    $display("FAIL %s src c%0d: got %h/%0d/%b want %h/%0d/%b", name, cyc,
                             SRC_ADDR, SRC_LEN, SRC_FIN, ws.addr, ws.len, ws.fin);
                end
                checks++;
                if (DST_ADDR !== wd.addr || DST_LEN !== wd.len || DST_FIN !== wd.fin) begin
                    errors++;
                    $display("FAIL %s dst c%0d: got %h/%0d/%b want %h/%0d/%b", name, cyc,
                             DST_ADDR, DST_LEN, DST_FIN, wd.addr, wd.len, wd.fin);
                end
                case (mode)
                    1:       begin sc = 1'b1; dc = 1'b1; end
                    2:       begin sc = cyc[0]; dc = !cyc[0]; end
                    default: begin sc = 1'($urandom); dc = 1'($urandom); end
                endcase
                SRC_COMMIT = sc;
                DST_COMMIT = dc;
                if (sc && blt && exp_src.size() != 0)   last_s = exp_src.pop_front();
                if (dc && blend && exp_dst.size() != 0) last_d = exp_dst.pop_front();
                cyc++;
                if (cyc > 4000) begin
                    checks++;
                    errors++;
                    $display("FAIL %s timeout: %0d bursts outstanding, want 0", name,
                             exp_src.size() + exp_dst.size());
                    fin_loop = 1'b1;
                end
            end
        end
        SRC_COMMIT = 1'b0;
        DST_COMMIT = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (ADDR_VALID !== 1'b0 || BUSY !== 1'b0 || SRC_ADDR !== 29'd0 || DST_ADDR !== 29'd0 ||
            SRC_LEN !== 8'd0 || DST_LEN !== 8'd0 || SRC_FIN !== 1'b0 || DST_FIN !== 1'b0) begin
            errors++;
            $display("FAIL %s: valid=%b busy=%b src=%h/%0d/%b dst=%h/%0d/%b, want all 0", name,
                     ADDR_VALID, BUSY, SRC_ADDR, SRC_LEN, SRC_FIN, DST_ADDR, DST_LEN, DST_FIN);
        end
    endtask

    task automatic test_reset();
        ARST = 1'b1; START = 1'b0; SRC_COMMIT = 1'b0; DST_COMMIT = 1'b0;
        set_cmd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge ACLK);
        check_idle_outputs("reset");
        ARST = 1'b0;
    endtask

    task automatic test_bit_basic();
        run_blit("bit_basic", 1, 0, 29'h1000, 29'h0, 12'd640, 12'd0, 0, 0, 0, 0, 11'd20, 11'd2, 0);
    endtask

    task automatic test_4k_split();
        run_blit("split4k", 1, 0, 29'h0FF8, 29'h0, 12'd64, 12'd0, 0, 0, 0, 0, 11'd8, 11'd1, 1);
    endtask

    task automatic test_pat_blend();
        run_blit("pat_blend", 0, 1, 29'h0, 29'h0, 12'd0, 12'd100, 0, 0, 11'd3, 11'd2, 11'd1, 11'd3, 1);
    endtask

    task automatic test_back_to_back();
        run_blit("dual_alt", 1, 1, 29'h2000, 29'h8000, 12'd64, 12'd64, 0, 0, 0, 0, 11'd40, 11'd1, 2);
        run_blit("dual_sim", 1, 1, 29'h2000, 29'h8000, 12'd64, 12'd64, 0, 0, 0, 0, 11'd40, 11'd1, 1);
        run_blit("dual_rnd", 1, 1, 29'h0FF0, 29'h1FFC, 12'd50, 12'd70, 11'd1, 11'd2, 11'd3, 11'd4, 11'd40, 11'd3, 0);
    endtask

    task automatic test_ignored();
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            case (k)
                0:       set_cmd(0, 0, 29'h100, 29'h200, 12'd10, 12'd10, 0, 0, 0, 0, 11'd4, 11'd4);
                1:       set_cmd(1, 1, 29'h100, 29'h200, 12'd10, 12'd10, 0, 0, 0, 0, 11'd0, 11'd4);
                default: set_cmd(1, 1, 29'h100, 29'h200, 12'd10, 12'd10, 0, 0, 0, 0, 11'd4, 11'd0);
            endcase
            START = 1'b1;
            @(negedge ACLK);
            START = 1'b0;
            repeat (3) begin
                checks++;
                if (BUSY !== 1'b0 || ADDR_VALID !== 1'b0) begin
                    errors++;
                    $display("FAIL ignored%0d: BUSY=%b ADDR_VALID=%b, want 0/0", k, BUSY, ADDR_VALID);
                end
                @(negedge ACLK);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge ACLK);
        set_cmd(1, 1, 29'h4000, 29'h9000, 12'd200, 12'd300, 11'd5, 11'd6, 11'd7, 11'd8, 11'd100, 11'd3);
        START = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
        SRC_COMMIT = 1'b1;
        repeat (5) @(negedge ACLK);
        ARST = 1'b1;
        @(negedge ACLK);
        check_idle_outputs("reset_mid");
        ARST = 1'b0;
        SRC_COMMIT = 1'b0;
        run_blit("after_reset", 1, 0, 29'h0FF8, 29'h0, 12'd32, 12'd0, 11'd0, 11'd1, 0, 0, 11'd30, 11'd2, 0);
    endtask

    task automatic test_random();
        bit          blt, blend;
        logic [28:0] sb, db;
        for (int n = 0; n < 25; n++) begin
            blt   = 1'($urandom);
            blend = blt ? 1'($urandom) : 1'b1;
            sb = {27'($urandom), 2'b00};
            db = {27'($urandom), 2'b00};
            if (n[0]) sb[11:2] = 10'h3F0 + 10'($urandom_range(0, 15));
            run_blit($sformatf("rand%0d", n), blt, blend, sb, db,
                     12'($urandom), 12'($urandom), 11'($urandom), 11'($urandom),
                     11'($urandom), 11'($urandom), 11'($urandom_range(1, 200)),
                     11'($urandom_range(1, 4)), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_bit_basic();
        test_4k_split();
        test_pat_blend();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
